// File: rtl/ball_frame_sequencer.sv
// ball_frame_sequencer: per-frame breakout ball controller. Each accepted frame tick
// runs ERASE (paint the ball black at its old spot), MOVE (one position/direction
// update with wall, paddle and miss handling) and DRAW (paint the ball at its new spot).
// The shared pixel writer is requested from ERASE through DRAW and is not released
// between the two painting passes.
module ball_frame_sequencer #(
  parameter int unsigned X_MAX       = 159,
  parameter int unsigned Y_MAX       = 119,
  parameter int unsigned BALL_SIZE   = 2,
  parameter int unsigned X0          = 80,
  parameter int unsigned Y0          = 60,
  parameter logic [1:0]  START_DIR   = 2'b00,
  parameter logic [2:0]  BALL_COLOUR = 3'b111
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_frame_tick,
  input  logic       i_paddle_hit,
  input  logic       i_pix_gnt,
  output logic       o_pix_req,
  output logic       o_pix_we,
  output logic [9:0] o_pix_x,
  output logic [9:0] o_pix_y,
  output logic [2:0] o_pix_colour,
  output logic [9:0] o_ball_x,
  output logic [9:0] o_ball_y,
  output logic [1:0] o_dir,
  output logic       o_busy,
  output logic       o_ball_lost
);

  // BALL_SIZE is a power of two (1..8), so the row/column split of the pixel
  // counter is a mask and a shift; the counter never exceeds 63.
  localparam int unsigned N_PIX     = BALL_SIZE * BALL_SIZE;
  localparam int unsigned LOG2_SIZE = $clog2(BALL_SIZE);
  localparam logic [5:0]  CNT_LAST  = 6'(N_PIX - 1);
  localparam logic [5:0]  COL_MASK  = 6'(BALL_SIZE - 1);
  localparam logic [9:0]  SIZE_W    = 10'(BALL_SIZE);
  localparam logic [9:0]  XMAX_W    = 10'(X_MAX);
  localparam logic [9:0]  YMAX_W    = 10'(Y_MAX);
  localparam logic [9:0]  X0_W      = 10'(X0);
  localparam logic [9:0]  Y0_W      = 10'(Y0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_MOVE  = 2'd2,
    S_DRAW  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_cnt;
  logic [9:0] r_ball_x;
  logic [9:0] r_ball_y;
  logic [1:0] r_dir;
  logic       r_ball_lost;

  logic       w_writing;
  logic       w_pix_we;
  logic       w_last;
  logic [9:0] w_col_off;
  logic [9:0] w_row_off;
  logic [9:0] w_nx;
  logic [9:0] w_ny;
  logic [1:0] w_ndir;
  logic       w_miss;

  assign w_writing = (r_state == S_ERASE) || (r_state == S_DRAW);
  assign w_pix_we  = i_pix_gnt && w_writing;
  assign w_last    = (r_cnt == CNT_LAST);
  assign w_col_off = {4'b0000, r_cnt & COL_MASK};
  assign w_row_off = {4'b0000, r_cnt >> LOG2_SIZE};

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; ticks are only honoured in IDLE, so ticks during a sequence are lost.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_frame_tick && i_enable) w_next = S_ERASE;
        else                          w_next = S_IDLE;
      end
      S_ERASE: begin
        if (w_pix_we && w_last) w_next = S_MOVE;
        else                    w_next = S_ERASE;
      end
      S_MOVE: begin
        w_next = S_DRAW;
      end
      S_DRAW: begin
        if (w_pix_we && w_last) w_next = S_IDLE;
        else                    w_next = S_DRAW;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Pixel-writer outputs; coordinates are forced to zero whenever no write is strobed.
  always_comb begin
    o_pix_req    = 1'b0;
    o_pix_colour = 3'b000;
    case (r_state)
      S_IDLE: begin
        o_pix_req    = 1'b0;
        o_pix_colour = 3'b000;
      end
      S_ERASE: begin
        o_pix_req    = 1'b1;
        o_pix_colour = 3'b000;
      end
      S_MOVE: begin
        o_pix_req    = 1'b1;
        o_pix_colour = 3'b000;
      end
      S_DRAW: begin
        o_pix_req    = 1'b1;
        o_pix_colour = BALL_COLOUR;
      end
      default: begin
        o_pix_req    = 1'b0;
        o_pix_colour = 3'b000;
      end
    endcase
    o_pix_we = w_pix_we;
    if (w_pix_we) begin
      o_pix_x = r_ball_x + w_col_off;
      o_pix_y = r_ball_y + w_row_off;
    end else begin
      o_pix_x = 10'd0;
      o_pix_y = 10'd0;
    end
    o_busy = (r_state != S_IDLE);
  end

  // Candidate position/direction for MOVE, each axis judged on the current values.
  always_comb begin
    w_nx   = r_ball_x;
    w_ny   = r_ball_y;
    w_ndir = r_dir;
    w_miss = 1'b0;
    if (!r_dir[0]) begin
      if (r_ball_x + SIZE_W > XMAX_W) w_ndir[0] = 1'b1;
      else                            w_nx      = r_ball_x + 10'd1;
    end else begin
      if (r_ball_x == 10'd0) w_ndir[0] = 1'b0;
      else                   w_nx      = r_ball_x - 10'd1;
    end
    if (r_dir[1]) begin
      if (r_ball_y == 10'd0) w_ndir[1] = 1'b0;
      else                   w_ny      = r_ball_y - 10'd1;
    end else if (i_paddle_hit) begin
      w_ndir[1] = 1'b1;
    end else if (r_ball_y + SIZE_W > YMAX_W) begin
      w_miss = 1'b1;
    end else begin
      w_ny = r_ball_y + 10'd1;
    end
  end

  // Pixel counter: advances only on an actual write, wraps to zero after the last pixel.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= 6'd0;
    end else if (w_pix_we) begin
      if (w_last) r_cnt <= 6'd0;
      else        r_cnt <= r_cnt + 6'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Ball state: updated once in MOVE; a miss respawns the ball and pulses ball_lost.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ball_x    <= X0_W;
      r_ball_y    <= Y0_W;
      r_dir       <= START_DIR;
      r_ball_lost <= 1'b0;
    end else if (r_state == S_MOVE) begin
      if (w_miss) begin
        r_ball_x <= X0_W;
        r_ball_y <= Y0_W;
        r_dir    <= START_DIR;
      end else begin
        r_ball_x <= w_nx;
        r_ball_y <= w_ny;
        r_dir    <= w_ndir;
      end
      r_ball_lost <= w_miss;
    end else begin
      r_ball_lost <= 1'b0;
    end
  end

  assign o_ball_x    = r_ball_x;
  assign o_ball_y    = r_ball_y;
  assign o_dir       = r_dir;
  assign o_ball_lost = r_ball_lost;

endmodule

// File: tb/tb_ball_frame_sequencer.sv
// Bench for ball_frame_sequencer: a per-cycle vector table on a default instance,
// plus hand-written frame sequences on two small-screen instances for wall, corner,
// paddle and miss handling, and a reset in the middle of DRAW.
module tb_ball_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             enable;
  logic             paddle_hit;
  logic             pix_gnt;
  logic [2:0]       tick;
  logic [2:0]       req, we, busy, lost;
  logic [2:0][9:0]  px, py, bx, by;
  logic [2:0][2:0]  col;
  logic [2:0][1:0]  dr;

  int vectors = 0;
  int miscompares = 0;

  // Instance 0: default parameters.
  ball_frame_sequencer u_a (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_frame_tick(tick[0]),
    .i_paddle_hit(paddle_hit), .i_pix_gnt(pix_gnt),
    .o_pix_req(req[0]), .o_pix_we(we[0]), .o_pix_x(px[0]), .o_pix_y(py[0]),
    .o_pix_colour(col[0]), .o_ball_x(bx[0]), .o_ball_y(by[0]), .o_dir(dr[0]),
    .o_busy(busy[0]), .o_ball_lost(lost[0])
  );

  // Instance 1: small screen, spawn (81,60) -> reaches (82,61) heading into the corner.
  ball_frame_sequencer #(.X_MAX(83), .Y_MAX(62), .X0(81), .Y0(60)) u_b (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_frame_tick(tick[1]),
    .i_paddle_hit(paddle_hit), .i_pix_gnt(pix_gnt),
    .o_pix_req(req[1]), .o_pix_we(we[1]), .o_pix_x(px[1]), .o_pix_y(py[1]),
    .o_pix_colour(col[1]), .o_ball_x(bx[1]), .o_ball_y(by[1]), .o_dir(dr[1]),
    .o_busy(busy[1]), .o_ball_lost(lost[1])
  );

  // Instance 2: small screen, spawn (82,60) against the right wall.
  ball_frame_sequencer #(.X_MAX(83), .Y_MAX(62), .X0(82), .Y0(60)) u_c (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_frame_tick(tick[2]),
    .i_paddle_hit(paddle_hit), .i_pix_gnt(pix_gnt),
    .o_pix_req(req[2]), .o_pix_we(we[2]), .o_pix_x(px[2]), .o_pix_y(py[2]),
    .o_pix_colour(col[2]), .o_ball_x(bx[2]), .o_ball_y(by[2]), .o_dir(dr[2]),
    .o_busy(busy[2]), .o_ball_lost(lost[2])
  );

  typedef struct {
    logic       tick, en, gnt;
    logic       req, we;
    logic [9:0] x, y;
    logic [2:0] col;
    logic       busy;
    logic [9:0] bx, by;
  } vec_t;

  vec_t vt[$];

  task automatic add_vec(input logic t, input logic en, input logic g,
                         input logic rq, input logic w, input int x, input int y,
                         input int c, input logic b, input int ex, input int ey);
    vec_t v;
    v.tick = t; v.en = en; v.gnt = g; v.req = rq; v.we = w;
    v.x = 10'(x); v.y = 10'(y); v.col = 3'(c); v.busy = b;
    v.bx = 10'(ex); v.by = 10'(ey);
    vt.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse one instance's tick and follow the frame until it returns to IDLE.
  task automatic run_frame(input int k, input logic ph,
                           output int lost_cycles, output int busy_cycles);
    lost_cycles = 0;
    busy_cycles = 0;
    paddle_hit = ph;
    tick[k] = 1'b1;
    step();
    tick[k] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!busy[k]) break;
      busy_cycles++;
      if (lost[k]) lost_cycles++;
      step();
    end
    paddle_hit = 1'b0;
  endtask

  initial begin
    int lc, bc;
    bit seen;

    // tick en gnt | req we x y col busy ball_x ball_y
    add_vec(1, 1, 1, 0, 0,  0,  0, 0, 0, 80, 60); // idle, tick accepted
    add_vec(0, 1, 1, 1, 1, 80, 60, 0, 1, 80, 60); // erase row-major
    add_vec(0, 1, 1, 1, 1, 81, 60, 0, 1, 80, 60);
    add_vec(0, 1, 1, 1, 1, 80, 61, 0, 1, 80, 60);
    add_vec(0, 1, 1, 1, 1, 81, 61, 0, 1, 80, 60);
    add_vec(0, 1, 1, 1, 0,  0,  0, 0, 1, 80, 60); // move
    add_vec(0, 1, 1, 1, 1, 81, 61, 7, 1, 81, 61); // draw at new spot
    add_vec(0, 1, 1, 1, 1, 82, 61, 7, 1, 81, 61);
    add_vec(0, 1, 1, 1, 1, 81, 62, 7, 1, 81, 61);
    add_vec(0, 1, 1, 1, 1, 82, 62, 7, 1, 81, 61);
    add_vec(0, 1, 1, 0, 0,  0,  0, 0, 0, 81, 61); // idle again
    add_vec(1, 1, 1, 0, 0,  0,  0, 0, 0, 81, 61); // second frame
    add_vec(0, 1, 1, 1, 1, 81, 61, 0, 1, 81, 61);
    add_vec(0, 0, 1, 1, 1, 82, 61, 0, 1, 81, 61); // enable drops, no abort
    add_vec(0, 0, 0, 1, 0,  0,  0, 0, 1, 81, 61); // grant withdrawn 3 cycles
    add_vec(0, 0, 0, 1, 0,  0,  0, 0, 1, 81, 61);
    add_vec(0, 0, 0, 1, 0,  0,  0, 0, 1, 81, 61);
    add_vec(0, 1, 1, 1, 1, 81, 62, 0, 1, 81, 61); // resumes at pixel 2
    add_vec(0, 1, 1, 1, 1, 82, 62, 0, 1, 81, 61);
    add_vec(0, 1, 1, 1, 0,  0,  0, 0, 1, 81, 61); // move
    add_vec(0, 1, 1, 1, 1, 82, 62, 7, 1, 82, 62);
    add_vec(1, 1, 1, 1, 1, 83, 62, 7, 1, 82, 62); // tick in DRAW dropped
    add_vec(0, 1, 1, 1, 1, 82, 63, 7, 1, 82, 62);
    add_vec(0, 1, 1, 1, 1, 83, 63, 7, 1, 82, 62);
    add_vec(0, 1, 1, 0, 0,  0,  0, 0, 0, 82, 62);
    add_vec(1, 0, 1, 0, 0,  0,  0, 0, 0, 82, 62); // tick with enable low
    add_vec(0, 1, 1, 0, 0,  0,  0, 0, 0, 82, 62); // nothing started

    reset = 1'b1; enable = 1'b1; paddle_hit = 1'b0; pix_gnt = 1'b1; tick = 3'b000;
    step();
    step();
    reset = 1'b0;

    check("reset_req",  int'(req[0]), 0);
    check("reset_busy", int'(busy[0]), 0);
    check("reset_ball", int'({bx[0], by[0], dr[0], lost[0]}), int'({10'd80, 10'd60, 2'b00, 1'b0}));
    check("reset_b_ball", int'({bx[1], by[1]}), int'({10'd81, 10'd60}));

    foreach (vt[i]) begin
      tick[0] = vt[i].tick;
      enable  = vt[i].en;
      pix_gnt = vt[i].gnt;
      #1;
      vectors++;
      if ({req[0], we[0], px[0], py[0], col[0], busy[0], bx[0], by[0]} !==
          {vt[i].req, vt[i].we, vt[i].x, vt[i].y, vt[i].col, vt[i].busy, vt[i].bx, vt[i].by}) begin
        miscompares++;
        $display("FAIL vec%0d: got req=%b we=%b x=%0d y=%0d col=%0d busy=%b ball=(%0d,%0d) expected req=%b we=%b x=%0d y=%0d col=%0d busy=%b ball=(%0d,%0d)",
                 i, req[0], we[0], px[0], py[0], col[0], busy[0], bx[0], by[0],
                 vt[i].req, vt[i].we, vt[i].x, vt[i].y, vt[i].col, vt[i].busy, vt[i].bx, vt[i].by);
      end
      @(posedge clk);
      #1;
    end
    tick[0] = 1'b0;
    enable  = 1'b1;
    pix_gnt = 1'b1;

    // Reset while instance 0 is painting.
    tick[0] = 1'b1;
    step();
    tick[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (busy[0] && col[0] == 3'd7) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check("reach_draw", int'(seen), 1);
    reset = 1'b1;
    step();
    check("rst_draw_req",  int'(req[0]), 0);
    check("rst_draw_busy", int'(busy[0]), 0);
    check("rst_draw_ball", int'({bx[0], by[0], dr[0]}), int'({10'd80, 10'd60, 2'b00}));
    reset = 1'b0;
    step();

    // Instance 2: right-wall bounce, then a miss from (82,61) heading down.
    run_frame(2, 1'b0, lc, bc);
    check("wall_ball", int'({bx[2], by[2]}), int'({10'd82, 10'd61}));
    check("wall_dir",  int'(dr[2]), 1);
    check("wall_busy_cycles", bc, 9);
    check("wall_no_lost", lc, 0);
    run_frame(2, 1'b0, lc, bc);
    check("miss_lost_cycles", lc, 1);
    check("miss_respawn", int'({bx[2], by[2]}), int'({10'd82, 10'd60}));
    check("miss_dir", int'(dr[2]), 0);
    check("miss_lost_low", int'(lost[2]), 0);

    // Instance 1: step to (82,61), then paddle hit on the corner.
    run_frame(1, 1'b0, lc, bc);
    check("b_step_ball", int'({bx[1], by[1]}), int'({10'd82, 10'd61}));
    check("b_step_dir", int'(dr[1]), 0);
    run_frame(1, 1'b1, lc, bc);
    check("corner_ball", int'({bx[1], by[1]}), int'({10'd82, 10'd61}));
    check("corner_dir",  int'(dr[1]), 3);
    check("corner_no_lost", lc, 0);
    run_frame(1, 1'b0, lc, bc);
    check("up_left_ball", int'({bx[1], by[1]}), int'({10'd81, 10'd60}));
    check("up_left_dir",  int'(dr[1]), 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
